// File: rtl/id_ctrl_pipe.sv
// ID-stage control decode into the ID/EX latch, with load-use stall and branch-flush bubbles.
// Latency: 1 cycle decode to ID/EX; pc_write/if_id_write are combinational stall controls.
// Backpressure: a load-use stall freezes PC and IF/ID for one cycle. CTRL_HAZARD_CNT_EN adds hazard counters.
module id_ctrl_pipe #(
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [5:0]            opcode,
   input  logic [REG_ADDR_W-1:0] if_id_rs,
   input  logic [REG_ADDR_W-1:0] if_id_rt,
   input  logic                  id_valid,
   input  logic                  branch_taken,
   output logic [3:0]            ex_control,
   output logic [2:0]            m_control,
   output logic [1:0]            wb_control,
   output logic [REG_ADDR_W-1:0] id_ex_rt,
   output logic                  id_ex_valid,
   output logic                  illegal_op,
   output logic                  pc_write,
   output logic                  if_id_write
`ifdef CTRL_HAZARD_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
`endif
);

   typedef struct packed {
      logic [3:0] ex;
      logic [2:0] m;
      logic [1:0] wb;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   ctrl_t      dec_ctrl;
   logic       dec_illegal;
   logic       rt_is_source;
   logic       load_use;
   logic       flush;
   logic       stall;
   logic [2:0] flush_left;

   always_comb begin
      dec_ctrl    = '0;
      dec_illegal = 1'b0;
      unique case (opcode)
         OP_LW:    dec_ctrl = '{ex: 4'b0100, m: 3'b100, wb: 2'b10};
         OP_SW:    dec_ctrl = '{ex: 4'b0100, m: 3'b010, wb: 2'b00};
         OP_BEQ:   dec_ctrl = '{ex: 4'b0001, m: 3'b001, wb: 2'b00};
         OP_RTYPE: dec_ctrl = '{ex: 4'b1010, m: 3'b000, wb: 2'b11};
         OP_ADDI:  dec_ctrl = '{ex: 4'b0100, m: 3'b000, wb: 2'b11};
         default:  dec_illegal = 1'b1;
      endcase
   end

   assign rt_is_source = (opcode == OP_RTYPE) | (opcode == OP_SW) | (opcode == OP_BEQ);

   // m_control[2] is MemRead of the instruction now in ID/EX, i.e. a load in flight.
   assign load_use = id_valid & id_ex_valid & m_control[2] & (id_ex_rt != '0) &
                     ((id_ex_rt == if_id_rs) | ((id_ex_rt == if_id_rt) & rt_is_source));

   assign flush       = branch_taken | (flush_left != 3'd0);
   assign stall       = load_use & ~flush;
   assign pc_write    = ~stall;
   assign if_id_write = ~stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         flush_left <= 3'd0;
      end else if (branch_taken) begin
         flush_left <= FLUSH_LOAD;
      end else if (flush_left != 3'd0) begin
         flush_left <= flush_left - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush || load_use) begin
         ex_control  <= '0;
         m_control   <= '0;
         wb_control  <= '0;
         id_ex_rt    <= '0;
         id_ex_valid <= 1'b0;
         illegal_op  <= 1'b0;
      end else begin
         ex_control  <= id_valid ? dec_ctrl.ex : 4'b0000;
         m_control   <= id_valid ? dec_ctrl.m  : 3'b000;
         wb_control  <= id_valid ? dec_ctrl.wb : 2'b00;
         id_ex_rt    <= if_id_rt;
         id_ex_valid <= id_valid;
         illegal_op  <= dec_illegal & id_valid;
      end
   end

`ifdef CTRL_HAZARD_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed bench for id_ctrl_pipe built with FLUSH_CYCLES=2 and CNT_W=4.
module tb_id_ctrl_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [4:0] if_id_rs;
   logic [4:0] if_id_rt;
   logic       id_valid;
   logic       branch_taken;
   logic [3:0] ex_control;
   logic [2:0] m_control;
   logic [1:0] wb_control;
   logic [4:0] id_ex_rt;
   logic       id_ex_valid;
   logic       illegal_op;
   logic       pc_write;
   logic       if_id_write;
`ifdef CTRL_HAZARD_CNT_EN
   logic [3:0] stall_cnt;
   logic [3:0] flush_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_ctrl_pipe #(
      .REG_ADDR_W   (5),
      .FLUSH_CYCLES (2),
      .CNT_W        (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .if_id_rs     (if_id_rs),
      .if_id_rt     (if_id_rt),
      .id_valid     (id_valid),
      .branch_taken (branch_taken),
      .ex_control   (ex_control),
      .m_control    (m_control),
      .wb_control   (wb_control),
      .id_ex_rt     (id_ex_rt),
      .id_ex_valid  (id_ex_valid),
      .illegal_op   (illegal_op),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write)
`ifdef CTRL_HAZARD_CNT_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Registered ID/EX bundle packed as {valid, illegal, rt, ex, m, wb}.
   function automatic logic [15:0] idex();
      return {2'b00, id_ex_valid, illegal_op, id_ex_rt, ex_control, m_control, wb_control};
   endfunction

   function automatic logic [15:0] mk(input logic v, input logic ill, input logic [4:0] rt,
                                      input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb);
      return {2'b00, v, ill, rt, ex, m, wb};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
      opcode   = op;
      if_id_rs = rs;
      if_id_rt = rt;
   endtask

   initial begin
      reset = 1'b1; branch_taken = 1'b0; id_valid = 1'b1;
      instr(6'b000000, 5'd1, 5'd2);

      // reset held for two edges
      cyc(); cyc();
      chk("reset_idex", idex(), 16'h0000);
      chk("reset_pcw", {15'd0, pc_write}, 16'd1);
      chk("reset_ifidw", {15'd0, if_id_write}, 16'd1);

      reset = 1'b0;
      cyc();
      chk("rtype_first", idex(), mk(1, 0, 5'd2, 4'b1010, 3'b000, 2'b11));

      // load-use stall on rs
      instr(6'b100011, 5'd1, 5'd5);
      cyc();
      chk("lw_latched", idex(), mk(1, 0, 5'd5, 4'b0100, 3'b100, 2'b10));
      instr(6'b000000, 5'd5, 5'd3);
      #1;
      chk("lu_pcw", {15'd0, pc_write}, 16'd0);
      chk("lu_ifidw", {15'd0, if_id_write}, 16'd0);
      cyc();
      chk("lu_bubble", idex(), 16'h0000);
      chk("lu_release_pcw", {15'd0, pc_write}, 16'd1);
      cyc();
      chk("lu_rtype", idex(), mk(1, 0, 5'd3, 4'b1010, 3'b000, 2'b11));

      // lw to $0 never stalls
      instr(6'b100011, 5'd1, 5'd0);
      cyc();
      instr(6'b000000, 5'd0, 5'd0);
      #1;
      chk("rt0_pcw", {15'd0, pc_write}, 16'd1);
      cyc();
      chk("rt0_rtype", idex(), mk(1, 0, 5'd0, 4'b1010, 3'b000, 2'b11));

      // addi rt is a destination, not a source
      instr(6'b100011, 5'd2, 5'd7);
      cyc();
      instr(6'b001000, 5'd1, 5'd7);
      #1;
      chk("addi_pcw", {15'd0, pc_write}, 16'd1);
      cyc();
      chk("addi_latched", idex(), mk(1, 0, 5'd7, 4'b0100, 3'b000, 2'b11));

      // lw rt=6 then beq reading rt=6 stalls
      instr(6'b100011, 5'd2, 5'd6);
      cyc();
      instr(6'b000100, 5'd1, 5'd6);
      #1;
      chk("beq_rt_pcw", {15'd0, pc_write}, 16'd0);
      cyc();
      chk("beq_bubble", idex(), 16'h0000);
      cyc();
      chk("beq_latched", idex(), mk(1, 0, 5'd6, 4'b0001, 3'b001, 2'b00));

      // taken branch with sw in ID: two bubbles, PC keeps writing
      instr(6'b101011, 5'd1, 5'd2);
      branch_taken = 1'b1;
      #1;
      chk("br_pcw0", {15'd0, pc_write}, 16'd1);
      cyc();
      branch_taken = 1'b0;
      chk("br_bubble1", idex(), 16'h0000);
      chk("br_pcw1", {15'd0, pc_write}, 16'd1);
      cyc();
      chk("br_bubble2", idex(), 16'h0000);
      cyc();
      chk("br_sw_resume", idex(), mk(1, 0, 5'd2, 4'b0100, 3'b010, 2'b00));

      // flush and load-use together: flush wins, PC writes
      instr(6'b100011, 5'd1, 5'd4);
      cyc();
      instr(6'b000000, 5'd4, 5'd0);
      branch_taken = 1'b1;
      #1;
      chk("fl_lu_pcw", {15'd0, pc_write}, 16'd1);
      cyc();
      branch_taken = 1'b0;
      chk("fl_lu_bubble1", idex(), 16'h0000);
      cyc();
      chk("fl_lu_bubble2", idex(), 16'h0000);
      cyc();
      chk("fl_lu_rtype", idex(), mk(1, 0, 5'd0, 4'b1010, 3'b000, 2'b11));

      // undecodable opcode
      instr(6'b111111, 5'd3, 5'd9);
      cyc();
      chk("illegal", idex(), mk(1, 1, 5'd9, 4'b0000, 3'b000, 2'b00));

      // empty IF/ID slot
      instr(6'b000000, 5'd3, 5'd8);
      id_valid = 1'b0;
      cyc();
      chk("invalid_slot", idex(), mk(0, 0, 5'd8, 4'b0000, 3'b000, 2'b00));
      id_valid = 1'b1;

      // reset in the middle of a flush clears the counter
      branch_taken = 1'b1;
      cyc();
      branch_taken = 1'b0;
      reset = 1'b1;
      cyc();
      chk("rst_midflush", idex(), 16'h0000);
      reset = 1'b0;
      cyc();
      chk("post_rst_normal", idex(), mk(1, 0, 5'd8, 4'b1010, 3'b000, 2'b11));

`ifdef CTRL_HAZARD_CNT_EN
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("cnt_reset", {8'd0, stall_cnt, flush_cnt}, 16'h0000);
      for (int i = 0; i < 20; i++) begin
         instr(6'b100011, 5'd1, 5'd5);
         cyc();
         instr(6'b000000, 5'd5, 5'd3);
         cyc();
         cyc();
      end
      chk("stall_sat", {12'd0, stall_cnt}, 16'd15);
      chk("flush_zero", {12'd0, flush_cnt}, 16'd0);
      branch_taken = 1'b1;
      cyc();
      branch_taken = 1'b0;
      cyc();
      chk("flush_cnt2", {12'd0, flush_cnt}, 16'd2);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("stall_clr", {12'd0, stall_cnt}, 16'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ctrl_pipe.md
Name: id_ctrl_pipe

Overview:
Parametrised decode-stage control block for the 5-stage MIPS/DLX pipeline. It decodes the ID-stage opcode into EX/M/WB control bundles and registers them into the ID/EX control latch with a valid bit. It includes load-use hazard detection (stall plus bubble) and branch-flush bubble insertion. It sits between the IF/ID register and the EX stage and drives the PC and IF/ID write enables.

Parameters:
REG_ADDR_W, 5, register-specifier width (rs/rt)
FLUSH_CYCLES, 1, bubbles inserted into ID/EX per taken branch (1..7)
CNT_W, 16, hazard-counter width (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous reset, active-high
opcode  in  6  instr[31:26] from IF/ID
if_id_rs  in  REG_ADDR_W  instr[25:21]
if_id_rt  in  REG_ADDR_W  instr[20:16]
id_valid  in  1  IF/ID holds a real instruction
branch_taken  in  1  one-cycle pulse from MEM: branch resolved taken
ex_control  out  4  registered {RegDst, ALUSrc, ALUOp[1:0]}
m_control  out  3  registered {MemRead, MemWrite, Branch}
wb_control  out  2  registered {RegWrite, ResultSel}; ResultSel 1 = ALU result, 0 = memory data
id_ex_rt  out  REG_ADDR_W  registered rt of the instruction in ID/EX
id_ex_valid  out  1  registered; 0 = bubble
illegal_op  out  1  registered; ID/EX holds an undecodable opcode
pc_write  out  1  combinational; 0 freezes the PC
if_id_write  out  1  combinational; 0 freezes IF/ID

Behaviour:
- Decode table (combinational; EX / M / WB):
  - 100011 lw: 0100 / 100 / 10
  - 101011 sw: 0100 / 010 / 00
  - 000100 beq: 0001 / 001 / 00
  - 000000 R-type: 1010 / 000 / 11
  - 001000 addi: 0100 / 000 / 11
  - Any other opcode: all zeros, illegal flag = 1.
  - No X outputs: every don't-care is driven 0.
- rt is a source register for R-type, sw and beq only.
- load_use = id_valid & id_ex_valid & m_control[2] & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt & rt_is_source)).
- Flush counter: width 3, reset 0.
  - branch_taken loads it with FLUSH_CYCLES-1 and makes flush active in that cycle.
  - flush = branch_taken | (cnt != 0); cnt decrements while nonzero.
  - branch_taken while cnt != 0 reloads the counter (no accumulation).
- ID/EX update, priority: reset > flush > load_use > normal.
  - reset: all registered outputs 0, cnt 0.
  - flush or load_use: bubble. All control bits 0, id_ex_valid 0, illegal_op 0, id_ex_rt 0.
  - normal: latch the decoded bundles, rt, illegal flag, and id_valid as the valid bit. If id_valid = 0, control bits are forced 0.
- pc_write = if_id_write = ~(load_use & ~flush). A flush overrides a stall: the PC keeps writing so the branch target can load.
- Load-use stall lasts exactly 1 cycle, because the bubble has MemRead = 0.
- Latency: decode to ID/EX outputs is 1 cycle.
- After reset deasserts: pc_write = 1, if_id_write = 1.
- Reset mid-flush: counter cleared, the next cycle is normal.

Optional Feature:
- Macro: CTRL_HAZARD_CNT_EN.
- Defined:
  - Adds outputs stall_cnt [CNT_W] and flush_cnt [CNT_W].
  - stall_cnt increments on each cycle with load_use & ~flush.
  - flush_cnt increments on each flush cycle.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. reset=1 for 2 cycles, then release with opcode=000000 and id_valid=1 -> during reset all outputs 0; 1 cycle after release ex=1010, m=000, wb=11, id_ex_valid=1.
2. lw with rt=5, then the next ID instruction is R-type with rs=5 -> in that cycle pc_write=0 and if_id_write=0; next cycle ID/EX is a bubble (valid=0, controls 0); the following cycle the R-type is latched with no further stall.
3. lw with rt=0, then R-type with rs=0 -> no stall. lw rt=7 followed by addi with rt=7 (rt not a source) -> no stall.
4. FLUSH_CYCLES=2, branch_taken pulse while a sw is in ID -> 2 consecutive bubble cycles; pc_write stays 1; then normal decode resumes.
5. Flush and load_use in the same cycle -> bubble inserted, pc_write=1. Opcode 111111 -> illegal_op=1, controls 0, valid=1 one cycle later.
6. With CTRL_HAZARD_CNT_EN and CNT_W=4: 20 load-use stalls -> stall_cnt saturates at 15; reset clears it to 0.
